// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and encodings for the hazard scoreboard and its forwarding selectors.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_scoreboard_pkg;

    // Register-address width carried inside a stage entry.
    localparam int ENTRY_AW = 5;

    // Tnew at E entry: cycles until the result can be forwarded.
    localparam logic [1:0] TNEW_PC   = 2'd0;
    localparam logic [1:0] TNEW_CAL  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;

    // Forwarding select encodings.
    localparam logic [1:0] FWD_GRF = 2'd0;
    localparam logic [1:0] FWD_E   = 2'd1;
    localparam logic [1:0] FWD_M   = 2'd2;
    localparam logic [1:0] FWD_W   = 2'd3;

    // One pipeline stage's hazard-relevant state.
    typedef struct packed {
        logic [ENTRY_AW-1:0] dest;
        logic                regwrite;
        logic [1:0]          tnew;
        logic [ENTRY_AW-1:0] rs;
        logic [ENTRY_AW-1:0] rt;
    } stage_entry_t;

    localparam stage_entry_t BUBBLE = '0;

    // Tnew one stage later; a ready result stays ready.
    function automatic logic [1:0] tnew_dec(input logic [1:0] tnew);
        return (tnew == TNEW_PC) ? TNEW_PC : tnew - 2'd1;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_fwd_select.sv
// Priority comparator choosing the forwarding source of one operand from E/M/W state.
// Latency: purely combinational.
// Backpressure: none; a younger match whose result is not ready yields GRF (the stall unit holds D).
module hazard_scoreboard_fwd_select
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter bit USE_E  = 1'b1
) (
    input  logic [REG_AW-1:0] src,
    input  logic [REG_AW-1:0] e_dest,
    input  logic              e_regwrite,
    input  logic [1:0]        e_tnew,
    input  logic [REG_AW-1:0] m_dest,
    input  logic              m_regwrite,
    input  logic [1:0]        m_tnew,
    input  logic [REG_AW-1:0] w_dest,
    input  logic              w_regwrite,
    output logic [1:0]        sel
);

    logic src_nz;
    logic e_match;
    logic m_match;
    logic w_match;

    // Youngest matching stage wins; a match that is not ready blocks older stages.
    always_comb begin
        src_nz  = (src != '0);
        e_match = USE_E && e_regwrite && src_nz && (e_dest == src);
        m_match = m_regwrite && src_nz && (m_dest == src);
        w_match = w_regwrite && src_nz && (w_dest == src);
        sel     = FWD_GRF;
        if (e_match) begin
            sel = (e_tnew == TNEW_PC) ? FWD_E : FWD_GRF;
        end else if (m_match) begin
            sel = (m_tnew == TNEW_PC) ? FWD_M : FWD_GRF;
        end else if (w_match) begin
            sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks dest/regwrite/Tnew of E, M, W and drives D- and E-stage forwarding selects plus stall stats.
// Latency: stage state updates one edge after D presents; fwd outputs are combinational from that state.
// Backpressure: stall (or kill) inserts a bubble into E; E, M and W always advance.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              kill,
    input  logic              d_valid,
    input  logic              d_regwrite,
    input  logic [REG_AW-1:0] d_dest,
    input  logic [1:0]        d_tnew,
    input  logic [REG_AW-1:0] d_rs,
    input  logic [REG_AW-1:0] d_rt,
    output logic [REG_AW-1:0] e_dest,
    output logic [REG_AW-1:0] m_dest,
    output logic [REG_AW-1:0] w_dest,
    output logic              e_regwrite,
    output logic              m_regwrite,
    output logic              w_regwrite,
    output logic [1:0]        e_tnew,
    output logic [1:0]        m_tnew,
    output logic [1:0]        fwd_d_rs,
    output logic [1:0]        fwd_d_rt,
    output logic [1:0]        fwd_e_rs,
    output logic [1:0]        fwd_e_rt,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  stall_max
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    stage_entry_t      e_q;
    stage_entry_t      d_entry;
    logic [REG_AW-1:0] m_dest_q;
    logic              m_regwrite_q;
    logic [1:0]        m_tnew_q;
    logic [REG_AW-1:0] w_dest_q;
    logic              w_regwrite_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  stall_max_q;
    logic [CNT_W-1:0]  run_q;
    logic [CNT_W-1:0]  run_next;
    logic [CNT_W-1:0]  cnt_next;

    // Entry presented by D; writes to register 0 never count as writes.
    always_comb begin
        d_entry          = BUBBLE;
        d_entry.dest     = d_dest;
        d_entry.regwrite = d_regwrite && (d_dest != '0);
        d_entry.tnew     = d_tnew;
        d_entry.rs       = d_rs;
        d_entry.rt       = d_rt;
    end

    // E captures D unless the instruction is held, discarded or absent.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_q <= BUBBLE;
        end else if (stall || kill || !d_valid) begin
            e_q <= BUBBLE;
        end else begin
            e_q <= d_entry;
        end
    end

    // M and W advance every cycle; Tnew counts down on the way into M.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_dest_q     <= '0;
            m_regwrite_q <= 1'b0;
            m_tnew_q     <= TNEW_PC;
            w_dest_q     <= '0;
            w_regwrite_q <= 1'b0;
        end else begin
            m_dest_q     <= e_q.dest;
            m_regwrite_q <= e_q.regwrite;
            m_tnew_q     <= tnew_dec(e_q.tnew);
            w_dest_q     <= m_dest_q;
            w_regwrite_q <= m_regwrite_q;
        end
    end

    // Saturating increments for the statistics counters.
    always_comb begin
        run_next = (run_q == CNT_MAX) ? CNT_MAX : run_q + 1'b1;
        cnt_next = (stall_cnt_q == CNT_MAX) ? CNT_MAX : stall_cnt_q + 1'b1;
    end

    // Total stalled cycles, current run length and the longest run seen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            stall_max_q <= '0;
            run_q       <= '0;
        end else if (stall) begin
            stall_cnt_q <= cnt_next;
            run_q       <= run_next;
            if (run_next > stall_max_q) begin
                stall_max_q <= run_next;
            end
        end else begin
            run_q <= '0;
        end
    end

    assign e_dest     = e_q.dest;
    assign e_regwrite = e_q.regwrite;
    assign e_tnew     = e_q.tnew;
    assign m_dest     = m_dest_q;
    assign m_regwrite = m_regwrite_q;
    assign m_tnew     = m_tnew_q;
    assign w_dest     = w_dest_q;
    assign w_regwrite = w_regwrite_q;
    assign stall_cnt  = stall_cnt_q;
    assign stall_max  = stall_max_q;

    hazard_scoreboard_fwd_select #(.REG_AW(REG_AW), .USE_E(1'b1)) u_fwd_d_rs (
        .src        (d_rs),
        .e_dest     (e_q.dest),
        .e_regwrite (e_q.regwrite),
        .e_tnew     (e_q.tnew),
        .m_dest     (m_dest_q),
        .m_regwrite (m_regwrite_q),
        .m_tnew     (m_tnew_q),
        .w_dest     (w_dest_q),
        .w_regwrite (w_regwrite_q),
        .sel        (fwd_d_rs)
    );

    hazard_scoreboard_fwd_select #(.REG_AW(REG_AW), .USE_E(1'b1)) u_fwd_d_rt (
        .src        (d_rt),
        .e_dest     (e_q.dest),
        .e_regwrite (e_q.regwrite),
        .e_tnew     (e_q.tnew),
        .m_dest     (m_dest_q),
        .m_regwrite (m_regwrite_q),
        .m_tnew     (m_tnew_q),
        .w_dest     (w_dest_q),
        .w_regwrite (w_regwrite_q),
        .sel        (fwd_d_rt)
    );

    // The E-stage operands can only come from older stages.
    hazard_scoreboard_fwd_select #(.REG_AW(REG_AW), .USE_E(1'b0)) u_fwd_e_rs (
        .src        (e_q.rs),
        .e_dest     ('0),
        .e_regwrite (1'b0),
        .e_tnew     (TNEW_PC),
        .m_dest     (m_dest_q),
        .m_regwrite (m_regwrite_q),
        .m_tnew     (m_tnew_q),
        .w_dest     (w_dest_q),
        .w_regwrite (w_regwrite_q),
        .sel        (fwd_e_rs)
    );

    hazard_scoreboard_fwd_select #(.REG_AW(REG_AW), .USE_E(1'b0)) u_fwd_e_rt (
        .src        (e_q.rt),
        .e_dest     ('0),
        .e_regwrite (1'b0),
        .e_tnew     (TNEW_PC),
        .m_dest     (m_dest_q),
        .m_regwrite (m_regwrite_q),
        .m_tnew     (m_tnew_q),
        .w_dest     (w_dest_q),
        .w_regwrite (w_regwrite_q),
        .sel        (fwd_e_rt)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed table-driven bench for hazard_scoreboard.
// Each vector drives D at the falling edge and checks the outputs before the next rising edge.
// Async-reset behaviour is exercised by a hand-written sequence between two tables.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int CNT_W  = 16;
    localparam int REG_AW = 5;
    localparam int NOUT   = 14;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              stall = 1'b0;
    logic              kill = 1'b0;
    logic              d_valid = 1'b0;
    logic              d_regwrite = 1'b0;
    logic [REG_AW-1:0] d_dest = '0;
    logic [1:0]        d_tnew = '0;
    logic [REG_AW-1:0] d_rs = '0;
    logic [REG_AW-1:0] d_rt = '0;
    logic [REG_AW-1:0] e_dest, m_dest, w_dest;
    logic              e_regwrite, m_regwrite, w_regwrite;
    logic [1:0]        e_tnew, m_tnew;
    logic [1:0]        fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
    logic [CNT_W-1:0]  stall_cnt, stall_max;

    hazard_scoreboard #(.CNT_W(CNT_W), .REG_AW(REG_AW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .stall      (stall),
        .kill       (kill),
        .d_valid    (d_valid),
        .d_regwrite (d_regwrite),
        .d_dest     (d_dest),
        .d_tnew     (d_tnew),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .e_dest     (e_dest),
        .m_dest     (m_dest),
        .w_dest     (w_dest),
        .e_regwrite (e_regwrite),
        .m_regwrite (m_regwrite),
        .w_regwrite (w_regwrite),
        .e_tnew     (e_tnew),
        .m_tnew     (m_tnew),
        .fwd_d_rs   (fwd_d_rs),
        .fwd_d_rt   (fwd_d_rt),
        .fwd_e_rs   (fwd_e_rs),
        .fwd_e_rt   (fwd_e_rt),
        .stall_cnt  (stall_cnt),
        .stall_max  (stall_max)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int kl;
        int v;
        int rw;
        int dst;
        int tn;
        int rs;
        int rt;
        int exp_out[NOUT];
    } vec_t;

    string out_name[NOUT] = '{"e_dest", "e_regwrite", "e_tnew", "m_dest", "m_regwrite", "m_tnew",
                              "w_dest", "w_regwrite", "fwd_d_rs", "fwd_d_rt", "fwd_e_rs", "fwd_e_rt",
                              "stall_cnt", "stall_max"};

    int compared   = 0;
    int mismatched = 0;

    vec_t tbl_a[14];
    vec_t tbl_b[14];

    localparam int LD = int'(TNEW_LOAD);
    localparam int CL = int'(TNEW_CAL);
    localparam int PC = int'(TNEW_PC);

    function automatic vec_t mk(int st, int kl, int v, int rw, int dst, int tn, int rs, int rt,
                                int ed, int erw, int et, int md, int mrw, int mt, int wd, int wrw,
                                int fdrs, int fdrt, int fers, int fert, int cnt, int mx);
        vec_t r;
        r.st = st; r.kl = kl; r.v = v; r.rw = rw;
        r.dst = dst; r.tn = tn; r.rs = rs; r.rt = rt;
        r.exp_out = '{ed, erw, et, md, mrw, mt, wd, wrw, fdrs, fdrt, fers, fert, cnt, mx};
        return r;
    endfunction

    function automatic int act_out(int k);
        case (k)
            0:       return int'(e_dest);
            1:       return int'(e_regwrite);
            2:       return int'(e_tnew);
            3:       return int'(m_dest);
            4:       return int'(m_regwrite);
            5:       return int'(m_tnew);
            6:       return int'(w_dest);
            7:       return int'(w_regwrite);
            8:       return int'(fwd_d_rs);
            9:       return int'(fwd_d_rt);
            10:      return int'(fwd_e_rs);
            11:      return int'(fwd_e_rt);
            12:      return int'(stall_cnt);
            default: return int'(stall_max);
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp_v);
        compared++;
        if (act != exp_v) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    task automatic drive(input int st, input int kl, input int v, input int rw,
                         input int dst, input int tn, input int rs, input int rt);
        stall      = st[0];
        kill       = kl[0];
        d_valid    = v[0];
        d_regwrite = rw[0];
        d_dest     = dst[REG_AW-1:0];
        d_tnew     = tn[1:0];
        d_rs       = rs[REG_AW-1:0];
        d_rt       = rt[REG_AW-1:0];
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < NOUT; k++) begin
            chk($sformatf("%s.%s", tag, out_name[k]), act_out(k), 0);
        end
    endtask

    task automatic run_vec(input vec_t vec, input string tag, input int idx);
        @(negedge clk);
        drive(vec.st, vec.kl, vec.v, vec.rw, vec.dst, vec.tn, vec.rs, vec.rt);
        #1;
        for (int k = 0; k < NOUT; k++) begin
            chk($sformatf("%s%0d.%s", tag, idx, out_name[k]), act_out(k), vec.exp_out[k]);
        end
    endtask

    initial begin
        // Outputs per vector: e(dest,rw,tnew) m(dest,rw,tnew) w(dest,rw) fwd(d_rs,d_rt,e_rs,e_rt) cnt max
        // Idle after reset, then load $8 / dependent add with one stall.
        tbl_a[0]  = mk(0,0,0,0, 0,0, 0,0,   0,0,0,   0,0,0,  0,0,  0,0,0,0, 0,0);
        tbl_a[1]  = mk(0,0,0,0, 0,0, 0,0,   0,0,0,   0,0,0,  0,0,  0,0,0,0, 0,0);
        tbl_a[2]  = mk(0,0,0,0, 0,0, 0,0,   0,0,0,   0,0,0,  0,0,  0,0,0,0, 0,0);
        tbl_a[3]  = mk(0,0,0,0, 0,0, 0,0,   0,0,0,   0,0,0,  0,0,  0,0,0,0, 0,0);
        tbl_a[4]  = mk(0,0,1,1, 8,LD,29,0,  0,0,0,   0,0,0,  0,0,  0,0,0,0, 0,0);
        tbl_a[5]  = mk(1,0,1,1, 10,CL,8,9,  8,1,2,   0,0,0,  0,0,  0,0,0,0, 0,0);
        tbl_a[6]  = mk(0,0,1,1, 10,CL,8,9,  0,0,0,   8,1,1,  0,0,  0,0,0,0, 1,1);
        tbl_a[7]  = mk(0,0,0,0, 0,0, 0,0,   10,1,1,  0,0,0,  8,1,  0,0,3,0, 1,1);
        // addu $5 then beq on $5 with one stall.
        tbl_a[8]  = mk(0,0,1,1, 5,CL,6,7,   0,0,0,   10,1,0, 0,0,  0,0,0,0, 1,1);
        tbl_a[9]  = mk(1,0,1,0, 0,PC,5,10,  5,1,1,   0,0,0,  10,1, 0,3,0,0, 1,1);
        tbl_a[10] = mk(0,0,1,0, 0,PC,5,10,  0,0,0,   5,1,0,  0,0,  2,0,0,0, 2,1);
        // Writes to $0 are never seen as writes.
        tbl_a[11] = mk(0,0,1,1, 0,PC,0,0,   0,0,0,   0,0,0,  5,1,  0,0,3,0, 2,1);
        tbl_a[12] = mk(0,0,1,1, 0,PC,0,0,   0,0,0,   0,0,0,  0,0,  0,0,0,0, 2,1);
        tbl_a[13] = mk(0,0,0,0, 0,0, 0,0,   0,0,0,   0,0,0,  0,0,  0,0,0,0, 2,1);

        // After a fresh reset: stall+kill for 4 edges, a 2-edge stall, then forwarding priority cases.
        tbl_b[0]  = mk(1,1,1,1, 4,CL,4,4,   0,0,0,   0,0,0,  0,0,  0,0,0,0, 0,0);
        tbl_b[1]  = mk(1,1,1,1, 4,CL,4,4,   0,0,0,   0,0,0,  0,0,  0,0,0,0, 1,1);
        tbl_b[2]  = mk(1,1,1,1, 4,CL,4,4,   0,0,0,   0,0,0,  0,0,  0,0,0,0, 2,2);
        tbl_b[3]  = mk(1,1,1,1, 4,CL,4,4,   0,0,0,   0,0,0,  0,0,  0,0,0,0, 3,3);
        tbl_b[4]  = mk(0,0,1,1, 4,CL,4,4,   0,0,0,   0,0,0,  0,0,  0,0,0,0, 4,4);
        tbl_b[5]  = mk(1,0,1,1, 6,CL,4,0,   4,1,1,   0,0,0,  0,0,  0,0,0,0, 4,4);
        tbl_b[6]  = mk(1,0,1,1, 6,CL,4,0,   0,0,0,   4,1,0,  0,0,  2,0,0,0, 5,4);
        tbl_b[7]  = mk(0,0,1,1, 6,CL,4,0,   0,0,0,   0,0,0,  4,1,  3,0,0,0, 6,4);
        tbl_b[8]  = mk(0,0,0,0, 0,0, 0,0,   6,1,1,   0,0,0,  0,0,  0,0,0,0, 6,4);
        tbl_b[9]  = mk(0,0,1,1, 31,PC,0,0,  0,0,0,   6,1,0,  0,0,  0,0,0,0, 6,4);
        tbl_b[10] = mk(0,0,1,1, 7,CL,31,6,  31,1,0,  0,0,0,  6,1,  1,3,0,0, 6,4);
        tbl_b[11] = mk(0,0,1,1, 31,LD,31,7, 7,1,1,   31,1,0, 0,0,  2,0,2,0, 6,4);
        tbl_b[12] = mk(0,0,0,0, 0,0, 31,7,  31,1,2,  7,1,0,  31,1, 0,2,3,2, 6,4);
        tbl_b[13] = mk(0,0,0,0, 0,0, 31,7,  0,0,0,   31,1,1, 7,1,  0,3,0,0, 6,4);

        // Held in reset across two clock edges.
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_vec(tbl_a[i], "a", i);
        end

        // Fill E, M and W, then pulse reset between clock edges.
        @(negedge clk); drive(0,0,1,1, 11,LD,1,2);
        @(negedge clk); drive(0,0,1,1, 12,CL,1,2);
        @(negedge clk); drive(0,0,1,1, 13,CL,1,2);
        @(negedge clk); drive(0,0,0,0, 0,0,0,0);
        #1;
        chk("fill.e_dest", int'(e_dest), 13);
        chk("fill.e_tnew", int'(e_tnew), 1);
        chk("fill.m_dest", int'(m_dest), 12);
        chk("fill.m_tnew", int'(m_tnew), 0);
        chk("fill.w_dest", int'(w_dest), 11);
        chk("fill.stall_cnt", int'(stall_cnt), 2);
        #1;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        #2;
        reset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_vec(tbl_b[i], "b", i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
